store_buffer: RTL

Posted-write buffer between the core's memory stage and `data_mem`. Stores are accepted in one cycle into a DEPTH-entry FIFO and drained in order to `data_mem` using its `memread`/`memwrite` + `clk_stall` protocol. Loads are serialised behind buffered stores unless forwarding is compiled in. The core no longer stalls for every store.

---
 rtl/store_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the memory stage and data_mem; drains stores in order
// and serialises loads behind them. Optional macro STORE_BUFFER_FWD_EN adds store-to-load forwarding.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_sign_mask,
   input  logic        cpu_memwrite,
   input  logic        cpu_memread,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_sign_mask,
   output logic        mem_memwrite,
   output logic        mem_memread,
   input  logic [31:0] mem_rdata,
   input  logic        mem_stall,
   output logic        sb_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

   state_t           state_q, state_d;
   logic             op_ld_q, op_ld_d;
   logic [31:0]      fifo_addr_q  [DEPTH];
   logic [31:0]      fifo_wdata_q [DEPTH];
   logic [3:0]       fifo_mask_q  [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ld_done_q, ld_done_d;
   logic [31:0]      cpu_rdata_q, cpu_rdata_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_mask_q, mem_mask_d;
   logic             mem_wr_q, mem_wr_d;
   logic             mem_rd_q, mem_rd_d;
   logic             sb_empty_q;

   logic             full, push, pop, ld_cap, ld_pend, ld_elig, fwd_take;
   logic [31:0]      fwd_data;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign push    = cpu_memwrite & ~full;
   assign ld_pend = cpu_memread & ~ld_done_q;

`ifdef STORE_BUFFER_FWD_EN
   logic             any_match, newest_word, ld_inflight;
   logic [PTR_W-1:0] idx;

   // Walk oldest to newest so the last hit recorded is the newest matching entry.
   always_comb begin
      any_match   = 1'b0;
      newest_word = 1'b0;
      fwd_data    = '0;
      idx         = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (fifo_addr_q[idx][31:2] == cpu_addr[31:2])) begin
            any_match   = 1'b1;
            newest_word = fifo_mask_q[idx][2];
            fwd_data    = fifo_wdata_q[idx];
         end
      end
   end

   assign ld_inflight = (state_q != S_IDLE) & op_ld_q;
   assign fwd_take    = ld_pend & ~ld_inflight & any_match & newest_word & cpu_sign_mask[2];
   assign ld_elig     = ld_pend & ~any_match;
`else
   assign fwd_take = 1'b0;
   assign fwd_data = '0;
   assign ld_elig  = ld_pend & (count_q == '0);
`endif

   always_comb begin
      state_d     = state_q;
      op_ld_d     = op_ld_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_mask_d  = mem_mask_q;
      mem_wr_d    = 1'b0;
      mem_rd_d    = 1'b0;
      pop         = 1'b0;
      ld_cap      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ld_elig) begin
               state_d     = S_REQ;
               op_ld_d     = 1'b1;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               mem_mask_d  = cpu_sign_mask;
               mem_rd_d    = 1'b1;
            end else if (count_q != '0) begin
               state_d     = S_REQ;
               op_ld_d     = 1'b0;
               mem_addr_d  = fifo_addr_q[rd_ptr_q];
               mem_wdata_d = fifo_wdata_q[rd_ptr_q];
               mem_mask_d  = fifo_mask_q[rd_ptr_q];
               mem_wr_d    = 1'b1;
            end
         end
         S_REQ: state_d = S_BUSY;
         S_BUSY: begin
            if (!mem_stall) begin
               state_d = S_IDLE;
               ld_cap  = op_ld_q;
               pop     = ~op_ld_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      ld_done_d   = ld_cap | fwd_take;
      cpu_rdata_d = cpu_rdata_q;
      if (ld_cap)
         cpu_rdata_d = mem_rdata;
      else if (fwd_take)
         cpu_rdata_d = fwd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_ld_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ld_done_q   <= 1'b0;
         cpu_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_mask_q  <= '0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         sb_empty_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_ld_q     <= op_ld_d;
         count_q     <= count_d;
         ld_done_q   <= ld_done_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_mask_q  <= mem_mask_d;
         mem_wr_q    <= mem_wr_d;
         mem_rd_q    <= mem_rd_d;
         sb_empty_q  <= (count_d == '0);
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Entry storage carries no reset; validity comes from count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q]  <= cpu_addr;
         fifo_wdata_q[wr_ptr_q] <= cpu_wdata;
         fifo_mask_q[wr_ptr_q]  <= cpu_sign_mask;
      end
   end

   assign cpu_rdata     = cpu_rdata_q;
   assign cpu_stall     = (cpu_memwrite & full) | (cpu_memread & ~ld_done_q);
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_sign_mask = mem_mask_q;
   assign mem_memwrite  = mem_wr_q;
   assign mem_memread   = mem_rd_q;
   assign sb_empty      = sb_empty_q;

endmodule
